// File: rtl/lfsr_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lfsr_pkg : mode encodings, 12-bit defaults and width-generic LFSR step  |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
package lfsr_pkg;

    localparam int LFSR_FIBONACCI = 0;
    localparam int LFSR_GALOIS    = 1;

    localparam int LFSR_MAX_WIDTH = 64;

    localparam logic [11:0] TAPS_FIB_12 = 12'hE08;
    localparam logic [11:0] TAPS_GAL_12 = 12'hC11;
    localparam logic [11:0] SEED_12     = 12'h001;

    typedef logic [LFSR_MAX_WIDTH-1:0] lfsr_word_t;

    // Operates on a zero-extended word; only the low 'width' bits are meaningful.
    function automatic lfsr_word_t lfsr_step(
        input lfsr_word_t  state,
        input lfsr_word_t  taps,
        input int unsigned width,
        input int          mode
    );
        lfsr_word_t mask;
        logic       msb;
        logic       fb;
        mask = (width >= LFSR_MAX_WIDTH) ? '1
             : ((lfsr_word_t'(1) << width) - lfsr_word_t'(1));
        msb  = |(state & (lfsr_word_t'(1) << (width - 1)));
        fb   = ^(state & taps & mask);
        if (mode == LFSR_GALOIS) begin
            return ((state << 1) ^ (msb ? taps : '0)) & mask;
        end
        return ((state << 1) | lfsr_word_t'(fb)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_next.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lfsr_next : combinational next-state of the LFSR, topology set by MODE  |
// | Revision  : 1.0                                                         |
// +-------------------------------------------------------------------------+
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_FIB_12,
    parameter int               MODE  = LFSR_FIBONACCI
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    generate
        if (MODE == LFSR_GALOIS) begin : g_galois
            assign next_state = WIDTH'(lfsr_step(lfsr_word_t'(state), lfsr_word_t'(TAPS),
                                                 WIDTH, LFSR_GALOIS));
        end else begin : g_fibonacci
            assign next_state = WIDTH'(lfsr_step(lfsr_word_t'(state), lfsr_word_t'(TAPS),
                                                 WIDTH, LFSR_FIBONACCI));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lfsr_gen : LFSR with step enable, parallel load, lock-up recovery and   |
// |            period detection against a reference value                   |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 12,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_FIB_12,
    parameter logic [WIDTH-1:0] SEED  = SEED_12,
    parameter int               MODE  = LFSR_FIBONACCI
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] step_count
);

    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] ref_val;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .state      (q),
        .next_state (next_state)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q           <= SEED;
            ref_val     <= SEED;
            step_count  <= '0;
            lockup      <= 1'b0;
            period_done <= 1'b0;
        end else begin
            lockup      <= 1'b0;
            period_done <= 1'b0;
            if (load) begin
                q          <= load_val;
                ref_val    <= load_val;
                step_count <= '0;
            end else if (en) begin
                if (q == '0) begin
                    // All-zero is a fixed point of both topologies; restart from SEED.
                    q          <= SEED;
                    ref_val    <= SEED;
                    step_count <= '0;
                    lockup     <= 1'b1;
                end else begin
                    q <= next_state;
                    if (next_state == ref_val) begin
                        period_done <= 1'b1;
                        step_count  <= '0;
                    end else begin
                        step_count <= step_count + WIDTH'(1);
                    end
                end
            end
        end
    end

    assign serial_out = q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_lfsr_gen : directed bench for Fibonacci and Galois lfsr_gen builds   |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module tb_lfsr_gen;
    import lfsr_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en_f = 1'b0, load_f = 1'b0;
    logic [11:0] load_val_f = 12'h000;
    logic [11:0] q_f, step_count_f;
    logic        serial_out_f, lockup_f, period_done_f;
    logic        en_g = 1'b0, load_g = 1'b0;
    logic [11:0] load_val_g = 12'h000;
    logic [11:0] q_g, step_count_g;
    logic        serial_out_g, lockup_g, period_done_g;

    int n_cmp = 0;
    int n_bad = 0;
    bit seen [0:4095];

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(12), .TAPS(12'hE08), .SEED(12'h001), .MODE(0)) dut_f (
        .clk(clk), .reset_n(reset_n), .en(en_f), .load(load_f), .load_val(load_val_f),
        .q(q_f), .serial_out(serial_out_f), .lockup(lockup_f),
        .period_done(period_done_f), .step_count(step_count_f)
    );

    lfsr_gen #(.WIDTH(12), .TAPS(12'hC11), .SEED(12'h001), .MODE(1)) dut_g (
        .clk(clk), .reset_n(reset_n), .en(en_g), .load(load_g), .load_val(load_val_g),
        .q(q_g), .serial_out(serial_out_g), .lockup(lockup_g),
        .period_done(period_done_g), .step_count(step_count_g)
    );

    task automatic do_reset();
        en_f = 0; load_f = 0; en_g = 0; load_g = 0;
        @(posedge clk); #1;
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (q_f !== 12'h001) begin n_bad++; $display("FAIL reset_q: got %h expected 001", q_f); end
        n_cmp++; if (step_count_f !== 12'h000) begin n_bad++; $display("FAIL reset_count: got %h expected 000", step_count_f); end
        n_cmp++; if ({lockup_f, period_done_f, serial_out_f} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b expected 000", {lockup_f, period_done_f, serial_out_f}); end
        reset_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (q_f !== 12'h001 || step_count_f !== 12'h000) begin
            n_bad++; $display("FAIL release_hold: got q=%h cnt=%h expected 001/000", q_f, step_count_f); end
    endtask

    task automatic test_fib_step();
        logic [11:0] exp_q [4] = '{12'h002, 12'h004, 12'h008, 12'h011};
        do_reset();
        en_f = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (q_f !== exp_q[i] || step_count_f !== 12'(i + 1)) begin
                n_bad++; $display("FAIL fib_step%0d: got q=%h cnt=%h expected %h/%h", i, q_f, step_count_f, exp_q[i], 12'(i + 1));
            end
        end
        en_f = 0;
    endtask

    task automatic test_reset_async();
        do_reset();
        en_f = 1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (q_f !== 12'h022) begin n_bad++; $display("FAIL pre_async_q: got %h expected 022", q_f); end
        #2 reset_n = 0;
        #1;
        n_cmp++; if (q_f !== 12'h001 || step_count_f !== 12'h000) begin
            n_bad++; $display("FAIL async_reset: got q=%h cnt=%h expected 001/000", q_f, step_count_f); end
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (q_f !== 12'h002) begin n_bad++; $display("FAIL post_reset_step: got %h expected 002", q_f); end
        en_f = 0;
    endtask

    task automatic test_period_fib();
        int pulses = 0, pulse_step = 0, dups = 0, cnt_err = 0;
        logic [11:0] q_at_pulse = 'x, cnt_at_pulse = 'x;
        for (int k = 0; k < 4096; k++) seen[k] = 0;
        do_reset();
        en_f = 1;
        for (int i = 1; i <= 4095; i++) begin
            @(posedge clk); #1;
            if (seen[q_f] || q_f == 12'h000) dups++;
            seen[q_f] = 1;
            if (step_count_f !== 12'((i == 4095) ? 0 : i)) cnt_err++;
            if (period_done_f) begin pulses++; pulse_step = i; q_at_pulse = q_f; cnt_at_pulse = step_count_f; end
        end
        en_f = 0;
        n_cmp++; if (pulses != 1 || pulse_step != 4095) begin
            n_bad++; $display("FAIL fib_period: got %0d pulses at step %0d expected 1 at 4095", pulses, pulse_step); end
        n_cmp++; if (q_at_pulse !== 12'h001 || cnt_at_pulse !== 12'h000) begin
            n_bad++; $display("FAIL fib_period_state: got q=%h cnt=%h expected 001/000", q_at_pulse, cnt_at_pulse); end
        n_cmp++; if (dups != 0) begin n_bad++; $display("FAIL fib_unique: got %0d repeats expected 0", dups); end
        n_cmp++; if (cnt_err != 0) begin n_bad++; $display("FAIL fib_count_track: got %0d errors expected 0", cnt_err); end
    endtask

    task automatic test_galois();
        int pulses = 0, pulse_step = 0;
        logic [11:0] q11 = 'x, q12 = 'x, q_at_pulse = 'x;
        do_reset();
        en_g = 1;
        for (int i = 1; i <= 4095; i++) begin
            @(posedge clk); #1;
            if (i == 11) q11 = q_g;
            if (i == 12) q12 = q_g;
            if (period_done_g) begin pulses++; pulse_step = i; q_at_pulse = q_g; end
        end
        en_g = 0;
        n_cmp++; if (q11 !== 12'h800) begin n_bad++; $display("FAIL gal_step11: got %h expected 800", q11); end
        n_cmp++; if (q12 !== 12'hC11) begin n_bad++; $display("FAIL gal_step12: got %h expected c11", q12); end
        n_cmp++; if (pulses != 1 || pulse_step != 4095 || q_at_pulse !== 12'h001) begin
            n_bad++; $display("FAIL gal_period: got %0d pulses step %0d q=%h expected 1/4095/001", pulses, pulse_step, q_at_pulse); end
    endtask

    task automatic test_lockup();
        do_reset();
        load_f = 1; load_val_f = 12'h000;
        @(posedge clk); #1;
        load_f = 0;
        n_cmp++; if (q_f !== 12'h000 || lockup_f !== 1'b0) begin
            n_bad++; $display("FAIL load_zero: got q=%h lockup=%b expected 000/0", q_f, lockup_f); end
        en_f = 1;
        @(posedge clk); #1;
        n_cmp++; if (q_f !== 12'h001 || lockup_f !== 1'b1 || step_count_f !== 12'h000 || period_done_f !== 1'b0) begin
            n_bad++; $display("FAIL lockup_recover: got q=%h lk=%b cnt=%h pd=%b expected 001/1/000/0", q_f, lockup_f, step_count_f, period_done_f); end
        @(posedge clk); #1;
        en_f = 0;
        n_cmp++; if (q_f !== 12'h002 || lockup_f !== 1'b0 || step_count_f !== 12'h001) begin
            n_bad++; $display("FAIL lockup_drop: got q=%h lk=%b cnt=%h expected 002/0/001", q_f, lockup_f, step_count_f); end
    endtask

    task automatic test_load_en();
        int pulses = 0, pulse_step = 0;
        logic [11:0] q_at_pulse = 'x;
        do_reset();
        en_f = 1;
        repeat (3) @(posedge clk);
        #1;
        load_f = 1; load_val_f = 12'h5A5;
        @(posedge clk); #1;
        load_f = 0;
        n_cmp++; if (q_f !== 12'h5A5 || step_count_f !== 12'h000 || period_done_f !== 1'b0 || lockup_f !== 1'b0) begin
            n_bad++; $display("FAIL load_wins: got q=%h cnt=%h pd=%b lk=%b expected 5a5/000/0/0", q_f, step_count_f, period_done_f, lockup_f); end
        for (int i = 1; i <= 4095; i++) begin
            @(posedge clk); #1;
            if (period_done_f) begin pulses++; pulse_step = i; q_at_pulse = q_f; end
        end
        en_f = 0;
        n_cmp++; if (pulses != 1 || pulse_step != 4095 || q_at_pulse !== 12'h5A5) begin
            n_bad++; $display("FAIL load_period: got %0d pulses step %0d q=%h expected 1/4095/5a5", pulses, pulse_step, q_at_pulse); end
    endtask

    task automatic test_hold();
        do_reset();
        en_f = 1;
        repeat (3) @(posedge clk);
        #1;
        en_f = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (q_f !== 12'h008 || step_count_f !== 12'h003 || lockup_f !== 1'b0 || period_done_f !== 1'b0) begin
                n_bad++; $display("FAIL hold%0d: got q=%h cnt=%h lk=%b pd=%b expected 008/003/0/0", i, q_f, step_count_f, lockup_f, period_done_f);
            end
        end
        en_f = 1;
        @(posedge clk); #1;
        en_f = 0;
        n_cmp++; if (q_f !== 12'h011 || step_count_f !== 12'h004 || serial_out_f !== 1'b0) begin
            n_bad++; $display("FAIL hold_resume: got q=%h cnt=%h so=%b expected 011/004/0", q_f, step_count_f, serial_out_f); end
    endtask

    initial begin
        test_reset();
        test_fib_step();
        test_reset_async();
        test_period_fib();
        test_galois();
        test_lockup();
        test_load_en();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
